// File: rtl/asg_pkg.sv
// Shared types and constants for the alternating-step keystream generator.
package asg_pkg;

  typedef enum logic [1:0] {
    StUnseeded,
    StWarmup,
    StRun
  } asg_state_e;

  localparam logic [1:0] SelNone = 2'b00;
  localparam logic [1:0] SelR1   = 2'b01;
  localparam logic [1:0] SelR2   = 2'b10;
  localparam logic [1:0] SelR3   = 2'b11;

  localparam logic [16:0] Taps1Default = 17'h12000;
  localparam logic [18:0] Taps2Default = 19'h72000;
  localparam logic [22:0] Taps3Default = 23'h420000;

endpackage

// File: rtl/asg_keystream_if.sv
// Seed-load and keystream handshake bundle between key logic, generator and consumer.
interface asg_keystream_if #(
  parameter int unsigned OUT_W = 8
);
  logic             seed_we;
  logic [1:0]       seed_sel;
  logic [31:0]      seed_data;
  logic [OUT_W-1:0] ks_data;
  logic             ks_valid;
  logic             ks_ready;

  modport master (
    output seed_we,
    output seed_sel,
    output seed_data,
    output ks_ready,
    input  ks_data,
    input  ks_valid
  );

  modport slave (
    input  seed_we,
    input  seed_sel,
    input  seed_data,
    input  ks_ready,
    output ks_data,
    output ks_valid
  );
endinterface

// File: rtl/asg_lfsr.sv
// Fibonacci LFSR with parallel load; a zero load value is replaced by 1 so the
// register can never lock up in the all-zero state.
module asg_lfsr #(
  parameter int unsigned  L    = 17,
  parameter logic [L-1:0] TAPS = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [L-1:0] load_val,
  input  logic         step,
  output logic         msb,
  output logic [L-1:0] state
);

  logic [L-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == '0) ? {{(L-1){1'b0}}, 1'b1} : load_val;
    end else if (step) begin
      state_d = {state_q[L-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign msb   = state_q[L-1];
  assign state = state_q;

endmodule

// File: rtl/asg_keystream.sv
// Alternating-step keystream generator: seeding FSM, warm-up discard and
// OUT_W-bit word packer with valid/ready back-pressure.
module asg_keystream
  import asg_pkg::*;
#(
  parameter int unsigned   L1    = 17,
  parameter int unsigned   L2    = 19,
  parameter int unsigned   L3    = 23,
  parameter logic [L1-1:0] TAPS1 = L1'(Taps1Default),
  parameter logic [L2-1:0] TAPS2 = L2'(Taps2Default),
  parameter logic [L3-1:0] TAPS3 = L3'(Taps3Default),
  parameter int unsigned   WARM  = 64,
  parameter int unsigned   OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  asg_keystream_if.slave   bus,
  input  logic             enable,
  output logic             running,
  output logic [2:0]       seeded
);

  localparam int unsigned CntW     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(OUT_W - 1);
  localparam logic [15:0]     WarmLast = 16'(WARM - 1);

  asg_state_e       state_q, state_d;
  logic [15:0]      warm_q, warm_d;
  logic [2:0]       seeded_q, seeded_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] ks_data_q, ks_data_d;
  logic             ks_valid_q, ks_valid_d;

  logic          seed_wr, step_asg;
  logic [2:0]    sel_onehot;
  logic          r1_msb, r2_msb, r3_msb;
  logic          r2_step, r3_step;
  logic [L1-1:0] r1_state;
  logic [L2-1:0] r2_state;
  logic [L3-1:0] r3_state;
  logic          ks_bit;
  logic [OUT_W-1:0] acc_shift;
  logic          unused_bits;

  assign seed_wr = bus.seed_we && (bus.seed_sel != SelNone);

  always_comb begin
    sel_onehot = 3'b000;
    unique case (bus.seed_sel)
      SelR1:   sel_onehot = 3'b001;
      SelR2:   sel_onehot = 3'b010;
      SelR3:   sel_onehot = 3'b100;
      default: sel_onehot = 3'b000;
    endcase
  end

  // R1's pre-step msb picks which of R2/R3 advances this step.
  assign r2_step = step_asg && r1_msb;
  assign r3_step = step_asg && !r1_msb;

  asg_lfsr #(.L(L1), .TAPS(TAPS1)) u_r1 (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_wr && sel_onehot[0]),
    .load_val (bus.seed_data[L1-1:0]),
    .step     (step_asg),
    .msb      (r1_msb),
    .state    (r1_state)
  );

  asg_lfsr #(.L(L2), .TAPS(TAPS2)) u_r2 (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_wr && sel_onehot[1]),
    .load_val (bus.seed_data[L2-1:0]),
    .step     (r2_step),
    .msb      (r2_msb),
    .state    (r2_state)
  );

  asg_lfsr #(.L(L3), .TAPS(TAPS3)) u_r3 (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_wr && sel_onehot[2]),
    .load_val (bus.seed_data[L3-1:0]),
    .step     (r3_step),
    .msb      (r3_msb),
    .state    (r3_state)
  );

  // Output bit uses post-step msbs: a stepping register's next msb is its current bit L-2.
  assign ks_bit = (r2_step ? r2_state[L2-2] : r2_msb) ^ (r3_step ? r3_state[L3-2] : r3_msb);
  assign acc_shift = OUT_W'({acc_q, ks_bit});

  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    seeded_d   = seeded_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
    step_asg   = 1'b0;

    if (ks_valid_q && bus.ks_ready) begin
      ks_valid_d = 1'b0;
    end

    if (seed_wr) begin
      seeded_d   = seeded_q | sel_onehot;
      acc_d      = '0;
      cnt_d      = '0;
      ks_valid_d = 1'b0;
      warm_d     = '0;
      if (&seeded_d) begin
        state_d = (WARM == 0) ? StRun : StWarmup;
      end else begin
        state_d = StUnseeded;
      end
    end else begin
      unique case (state_q)
        StUnseeded: ;
        StWarmup: begin
          if (enable && !bus.seed_we) begin
            step_asg = 1'b1;
            warm_d   = warm_q + 16'd1;
            if (warm_q == WarmLast) begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (enable && !(ks_valid_q && !bus.ks_ready) && !bus.seed_we) begin
            step_asg = 1'b1;
            acc_d    = acc_shift;
            if (cnt_q == CntLast) begin
              ks_data_d  = acc_shift;
              ks_valid_d = 1'b1;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        default: state_d = StUnseeded;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StUnseeded;
      warm_q     <= '0;
      seeded_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      seeded_q   <= seeded_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
    end
  end

  assign bus.ks_data  = ks_data_q;
  assign bus.ks_valid = ks_valid_q;
  assign running      = (state_q == StRun);
  assign seeded       = seeded_q;

  assign unused_bits = ^{bus.seed_data, r1_state};

endmodule

// File: tb/tb_asg_keystream.sv
// Scoreboard bench for asg_keystream: a bit-level software model of the three
// LFSRs fills an expected-word queue that is drained on each ks handshake.
module tb_asg_keystream;
  import asg_pkg::*;

  localparam int OW = 8;
  localparam int ML1 = 17, ML2 = 19, ML3 = 23;
  localparam logic [31:0] MT1 = 32'h12000, MT2 = 32'h72000, MT3 = 32'h420000;

  logic clk = 1'b0;
  logic reset, enable, seed_we, ks_ready;
  logic [1:0] seed_sel;
  logic [31:0] seed_data;
  logic run0, run64;
  logic [2:0] sd0, sd64;

  always #5 clk = ~clk;

  asg_keystream_if #(.OUT_W(OW)) if0 ();
  asg_keystream_if #(.OUT_W(OW)) if64 ();

  assign if0.seed_we    = seed_we;
  assign if0.seed_sel   = seed_sel;
  assign if0.seed_data  = seed_data;
  assign if0.ks_ready   = ks_ready;
  assign if64.seed_we   = seed_we;
  assign if64.seed_sel  = seed_sel;
  assign if64.seed_data = seed_data;
  assign if64.ks_ready  = ks_ready;

  asg_keystream #(.WARM(0), .OUT_W(OW)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .enable(enable), .running(run0), .seeded(sd0)
  );
  asg_keystream #(.WARM(64), .OUT_W(OW)) dut64 (
    .clk(clk), .reset(reset), .bus(if64), .enable(enable), .running(run64), .seeded(sd64)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [OW-1:0] q[$];
  logic [31:0] m1, m2, m3;

  function automatic logic [31:0] len_mask(input int len);
    return (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int len,
                                            input logic [31:0] taps);
    logic fb = 1'b0;
    for (int i = 0; i < len; i++) if (taps[i]) fb ^= s[i];
    return ((s << 1) | {31'd0, fb}) & len_mask(len);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] d, input int len);
    logic [31:0] v = d & len_mask(len);
    return (v == 0) ? 32'd1 : v;
  endfunction

  task automatic model_bit(output logic b);
    logic sel = m1[ML1-1];
    m1 = lfsr_next(m1, ML1, MT1);
    if (sel) m2 = lfsr_next(m2, ML2, MT2);
    else     m3 = lfsr_next(m3, ML3, MT3);
    b = m2[ML2-1] ^ m3[ML3-1];
  endtask

  task automatic model_word(output logic [OW-1:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < OW; i++) begin
      model_bit(b);
      w = {w[OW-2:0], b};
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; seed_we = 1'b0; seed_sel = 2'b00; seed_data = '0;
    enable = 1'b0; ks_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic seed_write(input logic [1:0] sel, input logic [31:0] d);
    seed_we = 1'b1; seed_sel = sel; seed_data = d;
    tick;
    seed_we = 1'b0; seed_sel = 2'b00;
  endtask

  task automatic seed_all(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    seed_write(SelR1, a);
    seed_write(SelR2, b);
    seed_write(SelR3, c);
    m1 = model_load(a, ML1);
    m2 = model_load(b, ML2);
    m3 = model_load(c, ML3);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; ks_ready = 1'b1;
    seed_we = 1'b1; seed_sel = SelR3; seed_data = 32'h1234;
    tick; tick;
    n_cmp++;
    if (sd0 !== 3'b000 || sd64 !== 3'b000) begin
      n_bad++; $display("FAIL reset_seeded: got %b/%b expected 000", sd0, sd64);
    end
    n_cmp++;
    if ({run0, run64, if0.ks_valid, if64.ks_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000",
                        {run0, run64, if0.ks_valid, if64.ks_valid});
    end
    n_cmp++;
    if (if0.ks_data !== 8'h00 || dut0.u_r3.state !== 23'd0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h expected 0/0", if0.ks_data, dut0.u_r3.state);
    end
    do_reset;
  endtask

  task automatic test_no_seed;
    int bad = 0;
    enable = 1'b1; ks_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick;
      if ({if0.ks_valid, if64.ks_valid, run0, run64} !== 4'b0000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL noseed_idle: got %0d active cycles expected 0", bad);
    end
    n_cmp++;
    if (sd0 !== 3'b000) begin
      n_bad++; $display("FAIL noseed_seeded: got %b expected 000", sd0);
    end
  endtask

  task automatic test_basic;
    logic [OW-1:0] w;
    int last = -1;
    do_reset;
    enable = 1'b1; ks_ready = 1'b1;
    seed_write(SelR1, 32'h1ACE5);
    seed_write(SelR2, 32'h2B00B);
    n_cmp++;
    if (run0 !== 1'b0 || sd0 !== 3'b011) begin
      n_bad++; $display("FAIL basic_partial_seed: got run=%b seeded=%b expected 0/011", run0, sd0);
    end
    seed_write(SelR3, 32'h3C0FFE);
    m1 = model_load(32'h1ACE5, ML1);
    m2 = model_load(32'h2B00B, ML2);
    m3 = model_load(32'h3C0FFE, ML3);
    n_cmp++;
    if (run0 !== 1'b1 || sd0 !== 3'b111) begin
      n_bad++; $display("FAIL basic_running: got run=%b seeded=%b expected 1/111", run0, sd0);
    end
    for (int i = 0; i < 4; i++) begin
      model_word(w);
      q.push_back(w);
    end
    for (int c = 0; c < 100 && q.size() > 0; c++) begin
      if (if0.ks_valid && ks_ready) begin
        w = q.pop_front();
        n_cmp++;
        if (if0.ks_data !== w) begin
          n_bad++; $display("FAIL basic_word: got %h expected %h", if0.ks_data, w);
        end
        if (last >= 0) begin
          n_cmp++;
          if (c - last != OW) begin
            n_bad++; $display("FAIL basic_spacing: got %0d cycles expected %0d", c - last, OW);
          end
        end
        last = c;
      end
      tick;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL basic_timeout: got %0d words missing expected 0", q.size());
    end
  endtask

  task automatic test_zero_seed;
    logic [OW-1:0] w;
    do_reset;
    enable = 1'b1; ks_ready = 1'b1;
    seed_all(32'h0, 32'h0, 32'h0);
    n_cmp++;
    if (sd0 !== 3'b111) begin
      n_bad++; $display("FAIL zero_seeded: got %b expected 111", sd0);
    end
    n_cmp++;
    if (dut0.u_r1.state !== 17'd1 || dut0.u_r2.state !== 19'd1 || dut0.u_r3.state !== 23'd1) begin
      n_bad++; $display("FAIL zero_subst: got %h/%h/%h expected 1/1/1",
                        dut0.u_r1.state, dut0.u_r2.state, dut0.u_r3.state);
    end
    for (int i = 0; i < 4; i++) begin
      model_word(w);
      q.push_back(w);
    end
    for (int c = 0; c < 100 && q.size() > 0; c++) begin
      if (if0.ks_valid && ks_ready) begin
        w = q.pop_front();
        n_cmp++;
        if (if0.ks_data !== w) begin
          n_bad++; $display("FAIL zero_word: got %h expected %h", if0.ks_data, w);
        end
      end
      tick;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL zero_timeout: got %0d words missing expected 0", q.size());
    end
  endtask

  task automatic test_backpressure;
    logic [OW-1:0] w, held;
    int bad = 0;
    do_reset;
    enable = 1'b1; ks_ready = 1'b0;
    seed_all(32'h1ACE5, 32'h2B00B, 32'h3C0FFE);
    for (int i = 0; i < 4; i++) begin
      model_word(w);
      q.push_back(w);
    end
    for (int c = 0; c < 20 && !if0.ks_valid; c++) tick;
    n_cmp++;
    if (if0.ks_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_first_valid: got %b expected 1", if0.ks_valid);
    end
    held = q[0];
    for (int c = 0; c < 20; c++) begin
      if (if0.ks_valid !== 1'b1 || if0.ks_data !== held) bad++;
      tick;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL bp_hold: got %0d unstable cycles expected 0 (word %h)", bad, held);
    end
    ks_ready = 1'b1;
    for (int c = 0; c < 100 && q.size() > 0; c++) begin
      if (if0.ks_valid && ks_ready) begin
        w = q.pop_front();
        n_cmp++;
        if (if0.ks_data !== w) begin
          n_bad++; $display("FAIL bp_word: got %h expected %h", if0.ks_data, w);
        end
      end
      tick;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL bp_timeout: got %0d words missing expected 0", q.size());
    end
  endtask

  task automatic test_warmup;
    logic [OW-1:0] w;
    logic b;
    int bad = 0;
    do_reset;
    enable = 1'b1; ks_ready = 1'b1;
    seed_all(32'h1ACE5, 32'h2B00B, 32'h3C0FFE);
    n_cmp++;
    if (run64 !== 1'b0) begin
      n_bad++; $display("FAIL warm_start: got running=%b expected 0", run64);
    end
    for (int i = 0; i < 64; i++) model_bit(b);
    for (int i = 0; i < 2; i++) begin
      model_word(w);
      q.push_back(w);
    end
    // Enable is dropped for ticks 31..40, so running should rise at tick 74.
    for (int i = 1; i <= 80; i++) begin
      enable = !(i > 30 && i <= 40);
      tick;
      if (run64 !== (i >= 74)) begin
        bad++;
        if (bad == 1) $display("FAIL warm_running: got %b at tick %0d expected %b",
                               run64, i, (i >= 74));
      end
    end
    n_cmp++;
    if (bad != 0) n_bad++;
    enable = 1'b1;
    for (int c = 0; c < 100 && q.size() > 0; c++) begin
      if (if64.ks_valid && ks_ready) begin
        w = q.pop_front();
        n_cmp++;
        if (if64.ks_data !== w) begin
          n_bad++; $display("FAIL warm_word: got %h expected %h", if64.ks_data, w);
        end
      end
      tick;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL warm_timeout: got %0d words missing expected 0", q.size());
    end
  endtask

  task automatic test_reseed;
    logic [OW-1:0] w;
    logic b;
    do_reset;
    enable = 1'b1; ks_ready = 1'b0;
    seed_all(32'h1ACE5, 32'h2B00B, 32'h3C0FFE);
    model_word(w);
    q.push_back(w);
    for (int c = 0; c < 20 && !if0.ks_valid; c++) tick;
    w = q.pop_front();
    n_cmp++;
    if (if0.ks_valid !== 1'b1 || if0.ks_data !== w) begin
      n_bad++; $display("FAIL reseed_first: got %b/%h expected 1/%h", if0.ks_valid, if0.ks_data, w);
    end
    seed_write(SelR2, 32'h5A5A5);
    m2 = model_load(32'h5A5A5, ML2);
    n_cmp++;
    if (if0.ks_valid !== 1'b0 || run0 !== 1'b1) begin
      n_bad++; $display("FAIL reseed_drop: got valid=%b run=%b expected 0/1", if0.ks_valid, run0);
    end
    ks_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      model_bit(b);
    end
    seed_write(SelR2, 32'h0F0F0);
    m2 = model_load(32'h0F0F0, ML2);
    for (int i = 0; i < 2; i++) begin
      model_word(w);
      q.push_back(w);
    end
    for (int c = 0; c < 100 && q.size() > 0; c++) begin
      if (if0.ks_valid && ks_ready) begin
        w = q.pop_front();
        n_cmp++;
        if (if0.ks_data !== w) begin
          n_bad++; $display("FAIL reseed_word: got %h expected %h", if0.ks_data, w);
        end
      end
      tick;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL reseed_timeout: got %0d words missing expected 0", q.size());
    end
  endtask

  initial begin
    test_reset;
    test_no_seed;
    test_basic;
    test_zero_seed;
    test_backpressure;
    test_warmup;
    test_reseed;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
